sdram_port_arbiter: RTL and testbench

Two-port arbiter sharing the single SDRAM controller request interface between an instruction-fetch requester (port 0) and a data/Wishbone requester (port 1). It sits between the user-project bus decode and the SDRAM controller, replacing direct wiring of `user_addr`/`rw`/`in_valid`. It serialises requests with round-robin fairness, holds `in_valid` until the controller is not busy, routes read data back to the owning port, and bounds every read with a timeout.

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/sdram_arb_rr.sv | 10 +
 rtl/sdram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM request arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  localparam int DEF_ADDR_W  = 23;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [DEF_DATA_W-1:0] TO_RDATA = '0;
endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker: on a tie the port that did not win last goes.
module sdram_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);
  assign any   = |valid;
  assign grant = (&valid) ? ~last_grant : valid[1];
endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises fetch and data requests onto one SDRAM controller port,
// routing completions back to the owner with a bounded read wait.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p1_valid,
  input  logic              p0_rw,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ready,
  output logic              p1_ready,
  output logic              p0_resp_valid,
  output logic              p1_resp_valid,
  output logic              p0_resp_err,
  output logic              p1_resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid,
  input  logic [DATA_W-1:0] ctrl_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          own, last_grant;
  logic          grant, any;
  logic          take, acc, rd_done, rd_to, done;

  sdram_arb_rr u_rr (
    .valid      ({p1_valid, p0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  always_comb begin
    state_n = state;
    take    = 1'b0;
    acc     = 1'b0;
    rd_done = 1'b0;
    rd_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any && !rst) begin
          take    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!ctrl_busy) begin
          acc     = 1'b1;
          state_n = ctrl_rw ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        // out_valid on the final counted cycle still wins over the timeout
        if (ctrl_out_valid) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rd_to   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign p0_ready      = take & ~grant;
  assign p1_ready      = take & grant;
  assign ctrl_in_valid = (state == ISSUE);
  assign done          = (acc & ctrl_rw) | rd_done | rd_to;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own           <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      ctrl_addr     <= '0;
      ctrl_rw       <= 1'b0;
      ctrl_wdata    <= '0;
      resp_rdata    <= '0;
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      p0_resp_err   <= 1'b0;
      p1_resp_err   <= 1'b0;
    end else begin
      p0_resp_valid <= done & ~own;
      p1_resp_valid <= done & own;
      p0_resp_err   <= rd_to & ~own;
      p1_resp_err   <= rd_to & own;
      if (take) begin
        own        <= grant;
        last_grant <= grant;
        ctrl_rw    <= grant ? p1_rw : p0_rw;
        ctrl_addr  <= grant ? p1_addr : p0_addr;
        ctrl_wdata <= grant ? p1_wdata : p0_wdata;
      end
      if (acc) cnt <= '0;
      if (state == WAIT_RD) cnt <= cnt + CW'(1);
      if (rd_done) resp_rdata <= ctrl_rdata;
      if (rd_to) resp_rdata <= DATA_W'(TO_RDATA);
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: grant table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_sdram_port_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p1_valid, p0_rw, p1_rw;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ready, p1_ready;
  logic          p0_resp_valid, p1_resp_valid;
  logic          p0_resp_err, p1_resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] ctrl_addr;
  logic          ctrl_rw;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_in_valid;
  logic          ctrl_busy, ctrl_out_valid;
  logic [DW-1:0] ctrl_rdata;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_rw(p0_rw), .p1_rw(p1_rw),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_resp_valid(p0_resp_valid),
    .p1_resp_valid(p1_resp_valid),
    .p0_resp_err(p0_resp_err), .p1_resp_err(p1_resp_err),
    .resp_rdata(resp_rdata),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw),
    .ctrl_wdata(ctrl_wdata),
    .ctrl_in_valid(ctrl_in_valid),
    .ctrl_busy(ctrl_busy),
    .ctrl_out_valid(ctrl_out_valid),
    .ctrl_rdata(ctrl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0, v1;
    logic r0, r1;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    p0_valid = 0; p1_valid = 0; p0_rw = 0; p1_rw = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    ctrl_busy = 0; ctrl_out_valid = 0; ctrl_rdata = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    nxt();
    nxt();
    rst = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, {p0_ready, p1_ready}, 0);
    chk({nm, "_rv"}, {p0_resp_valid, p1_resp_valid}, 0);
    chk({nm, "_err"}, {p0_resp_err, p1_resp_err}, 0);
    chk({nm, "_inv"}, ctrl_in_valid, 0);
    chk({nm, "_rdata"}, resp_rdata, 0);
    chk({nm, "_ctrl"}, {ctrl_addr, ctrl_rw, ctrl_wdata}, 0);
  endtask

  // reference model state for the random run
  logic          rv[2], rrw[2];
  logic [AW-1:0] ra[2];
  logic [DW-1:0] rd[2];
  bit            m_txn, m_acc, m_port, m_rw, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  int            m_acc_cyc;
  bit            er_v[2];
  bit            er_err, er_rd;
  logic [DW-1:0] er_rdata;

  initial begin
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 0};
    tbl[4] = '{1, 0, 1, 0};
    tbl[5] = '{1, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0};
    tbl[7] = '{1, 1, 1, 0};

    do_reset();
    smp();
    chk_zero("reset");

    // grant table: each granted request is a write with busy low
    for (int i = 0; i < 8; i++) begin
      nxt();
      p0_valid = tbl[i].v0; p1_valid = tbl[i].v1;
      p0_rw = 1; p1_rw = 1;
      p0_addr = AW'(i); p1_addr = AW'(i + 16);
      smp();
      chk($sformatf("tbl%0d_rdy", i), {p0_ready, p1_ready},
          {tbl[i].r0, tbl[i].r1});
      nxt();
      p0_valid = 0; p1_valid = 0;
      smp();
      chk($sformatf("tbl%0d_inv", i), ctrl_in_valid,
          tbl[i].r0 | tbl[i].r1);
      if (tbl[i].r0 | tbl[i].r1) begin
        chk($sformatf("tbl%0d_addr", i), ctrl_addr,
            tbl[i].r0 ? i : i + 16);
        nxt();
        smp();
        chk($sformatf("tbl%0d_rv", i),
            {p0_resp_valid, p1_resp_valid},
            {tbl[i].r0, tbl[i].r1});
      end
    end
    nxt();

    // tie held through four requests after reset
    do_reset();
    p0_valid = 1; p1_valid = 1; p0_rw = 1; p1_rw = 1;
    for (int g = 0; g < 4; g++) begin
      smp();
      chk($sformatf("tie%0d", g), {p0_ready, p1_ready},
          (g % 2 == 0) ? 2'b10 : 2'b01);
      nxt();
      if (g == 3) begin p0_valid = 0; p1_valid = 0; end
      smp();
      chk($sformatf("tie%0d_issue", g), ctrl_in_valid, 1);
      nxt();
    end
    nxt();

    // single p0 write
    p0_valid = 1; p0_rw = 1;
    p0_addr = 23'h000100; p0_wdata = 32'hA5A5A5A5;
    smp();
    chk("wr_rdy", {p0_ready, p1_ready}, 2'b10);
    nxt();
    p0_valid = 0;
    smp();
    chk("wr_ctrl", {ctrl_in_valid, ctrl_addr, ctrl_rw, ctrl_wdata},
        {1'b1, 23'h000100, 1'b1, 32'hA5A5A5A5});
    nxt();
    smp();
    chk("wr_resp", {p0_resp_valid, p0_resp_err, p1_resp_valid}, 3'b100);
    chk("wr_inv_off", ctrl_in_valid, 0);
    nxt();
    smp();
    chk("wr_pulse", p0_resp_valid, 0);

    // p1 read with busy stall, data five cycles after acceptance
    nxt();
    p1_valid = 1; p1_rw = 0; p1_addr = 23'h000200; ctrl_busy = 1;
    smp();
    chk("rd_rdy", {p0_ready, p1_ready}, 2'b01);
    nxt();
    p1_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      ctrl_busy = (i < 4);
      smp();
      chk($sformatf("rd_hold%0d", i), {ctrl_in_valid, ctrl_addr, ctrl_rw},
          {1'b1, 23'h000200, 1'b0});
      nxt();
    end
    for (int i = 5; i <= 9; i++) begin
      if (i == 9) begin
        ctrl_out_valid = 1; ctrl_rdata = 32'h12345678;
      end
      smp();
      chk($sformatf("rd_wait%0d", i), {p0_resp_valid, p1_resp_valid}, 0);
      nxt();
    end
    ctrl_out_valid = 0; ctrl_rdata = 32'hFFFFFFFF;
    smp();
    chk("rd_resp", {p0_resp_valid, p1_resp_valid, p1_resp_err}, 3'b010);
    chk("rd_data", resp_rdata, 32'h12345678);

    // read timeout, then back-to-back grant in the error cycle
    nxt();
    p0_valid = 1; p0_rw = 0; p0_addr = 23'h000300;
    smp();
    chk("to_rdy", p0_ready, 1);
    nxt();
    p0_valid = 0;
    smp();
    chk("to_inv", ctrl_in_valid, 1);
    nxt();
    for (int i = 2; i <= 9; i++) begin
      smp();
      chk($sformatf("to_wait%0d", i), p0_resp_valid, 0);
      nxt();
    end
    p1_valid = 1; p1_rw = 1; p1_addr = 23'h000400;
    smp();
    chk("to_resp", {p0_resp_valid, p0_resp_err}, 2'b11);
    chk("to_data", resp_rdata, 0);
    chk("to_next_rdy", p1_ready, 1);
    nxt();
    p1_valid = 0;
    nxt();
    smp();
    chk("to_next_resp", {p1_resp_valid, p1_resp_err}, 2'b10);

    // spurious out_valid while idle
    nxt();
    ctrl_out_valid = 1; ctrl_rdata = 32'hCAFEF00D;
    nxt();
    nxt();
    ctrl_out_valid = 0;
    smp();
    chk("spur_rv", {p0_resp_valid, p1_resp_valid}, 0);
    nxt();
    smp();
    chk("spur_rv2", {p0_resp_valid, p1_resp_valid}, 0);

    // reset while waiting for read data
    nxt();
    p0_valid = 1; p0_rw = 0; p0_addr = 23'h000500;
    nxt();
    p0_valid = 0;
    nxt();
    nxt();
    rst = 1;
    nxt();
    rst = 0; ctrl_out_valid = 1; ctrl_rdata = 32'hDEADBEEF;
    smp();
    chk_zero("mid_rst");
    nxt();
    ctrl_out_valid = 0;
    smp();
    chk("mid_rst_rv", {p0_resp_valid, p1_resp_valid, resp_rdata}, 0);
    nxt();
    p0_valid = 1; p1_valid = 1; p0_rw = 1; p1_rw = 1;
    smp();
    chk("mid_rst_tie", {p0_ready, p1_ready}, 2'b10);
    nxt();
    p0_valid = 0; p1_valid = 0;
    nxt();
    nxt();

    // randomized run against the reference model
    do_reset();
    m_txn = 0; m_acc = 0; m_last = 1; m_port = 0; m_rw = 0;
    m_addr = '0; m_wd = '0; m_acc_cyc = 0;
    er_v[0] = 0; er_v[1] = 0; er_err = 0; er_rd = 0; er_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 0; rrw[p] = 0; ra[p] = '0; rd[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      bit ch, e0, e1;
      for (int p = 0; p < 2; p++) begin
        if (!rv[p] && $urandom_range(0, 2) == 0) begin
          rv[p]  = 1;
          rrw[p] = 1'($urandom_range(0, 1));
          ra[p]  = AW'($urandom());
          rd[p]  = $urandom();
        end
      end
      p0_valid = rv[0]; p0_rw = rrw[0];
      p0_addr = ra[0]; p0_wdata = rd[0];
      p1_valid = rv[1]; p1_rw = rrw[1];
      p1_addr = ra[1]; p1_wdata = rd[1];
      ctrl_busy = ($urandom_range(0, 3) == 0);
      if ((c / 200) % 2 == 1)
        ctrl_out_valid = ($urandom_range(0, 19) == 0);
      else
        ctrl_out_valid = ($urandom_range(0, 2) == 0);
      ctrl_rdata = $urandom();
      smp();
      ch = (rv[0] && rv[1]) ? !m_last : rv[1];
      e0 = !m_txn && rv[0] && !ch;
      e1 = !m_txn && rv[1] && ch;
      chk("rnd_rdy", {p0_ready, p1_ready}, {e0, e1});
      chk("rnd_inv", ctrl_in_valid, m_txn && !m_acc);
      if (m_txn && !m_acc)
        chk("rnd_ctrl", {ctrl_addr, ctrl_rw, ctrl_wdata},
            {m_addr, m_rw, m_wd});
      chk("rnd_rv", {p0_resp_valid, p1_resp_valid}, {er_v[0], er_v[1]});
      if (er_v[0] || er_v[1])
        chk("rnd_err", p0_resp_err | p1_resp_err, er_err);
      if (er_rd)
        chk("rnd_rdata", resp_rdata, er_rdata);
      er_v[0] = 0; er_v[1] = 0; er_err = 0; er_rd = 0;
      if (!m_txn) begin
        if (rv[0] || rv[1]) begin
          m_txn = 1; m_acc = 0; m_port = ch; m_last = ch;
          m_rw = rrw[ch]; m_addr = ra[ch]; m_wd = rd[ch];
        end
      end else if (!m_acc) begin
        if (!ctrl_busy) begin
          if (m_rw) begin
            er_v[m_port] = 1; m_txn = 0;
          end else begin
            m_acc = 1; m_acc_cyc = c;
          end
        end
      end else if (ctrl_out_valid) begin
        er_v[m_port] = 1; er_rd = 1; er_rdata = ctrl_rdata; m_txn = 0;
      end else if (c - m_acc_cyc == TO) begin
        er_v[m_port] = 1; er_err = 1; er_rd = 1; er_rdata = '0;
        m_txn = 0;
      end
      nxt();
      if (e0) rv[0] = 0;
      if (e1) rv[1] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
